// File: rtl/kc_clk_enables.sv
// kc_clk_enables: reset sequencer and clock-enable generator for the KC85/4 core.
// Holds the core in reset until the PLL has been locked for LOCK_WAIT cycles, then
// emits single-cycle pixel (/8) and Z80 (/32, /16, /8, /4) enables on the PLL clock.
module kc_clk_enables #(
  parameter int unsigned LOCK_WAIT = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic [1:0] turbo,
  input  logic       cpu_hold,
  output logic       sys_rst_n,
  output logic       ce_pix,
  output logic       ce_cpu,
  output logic       lock_lost
);

  localparam logic [1:0] StWaitLock = 2'd0;
  localparam logic [1:0] StStab     = 2'd1;
  localparam logic [1:0] StRun      = 2'd2;

  localparam logic [15:0] LockTerm = 16'(LOCK_WAIT - 1);

  logic        lk_meta_q, lk_s_q;
  logic [1:0]  state_q, state_d;
  logic [15:0] lock_cnt_q, lock_cnt_d;
  logic [2:0]  pix_cnt_q, pix_cnt_d;
  logic [4:0]  cpu_cnt_q, cpu_cnt_d;
  logic [1:0]  div_sel_q, div_sel_d;
  logic        sys_rst_n_q;
  logic        lock_lost_q, lock_lost_d;

  logic        run_q, run_d, stay_run;
  logic [4:0]  cpu_term;
  logic        cpu_at_term;

  // Two-flop synchronizer for the asynchronous PLL lock flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta_q <= 1'b0;
      lk_s_q    <= 1'b0;
    end else begin
      lk_meta_q <= pll_locked;
      lk_s_q    <= lk_meta_q;
    end
  end

  // Sequencer next state: wait for lock, count a stable period, then run.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitLock: if (lk_s_q) state_d = StStab;
      StStab: begin
        if (!lk_s_q) begin
          state_d = StWaitLock;
        end else if (lock_cnt_q == LockTerm) begin
          state_d = StRun;
        end
      end
      StRun:   if (!lk_s_q) state_d = StWaitLock;
      default: state_d = StWaitLock;
    endcase
  end

  assign run_q    = (state_q == StRun);
  assign run_d    = (state_d == StRun);
  // Counters only advance while RUN persists across the edge; entry and exit clear them.
  assign stay_run = run_q && run_d;

  // Terminal count of the CPU divider for the latched divisor.
  always_comb begin
    cpu_term = 5'd31;
    unique case (div_sel_q)
      2'd0: cpu_term = 5'd31;
      2'd1: cpu_term = 5'd15;
      2'd2: cpu_term = 5'd7;
      2'd3: cpu_term = 5'd3;
      default: cpu_term = 5'd31;
    endcase
  end

  assign cpu_at_term = (cpu_cnt_q == cpu_term);

  // Enables decode from registered state; a hold at terminal defers the CPU pulse.
  always_comb begin
    ce_pix = run_q && (pix_cnt_q == 3'd7);
    ce_cpu = run_q && cpu_at_term && !cpu_hold;
  end

  // Next-state for stabilisation counter, dividers, divisor latch and sticky flag.
  always_comb begin
    lock_cnt_d  = (state_q == StStab) ? lock_cnt_q + 16'd1 : 16'd0;
    pix_cnt_d   = stay_run ? pix_cnt_q + 3'd1 : 3'd0;

    cpu_cnt_d = 5'd0;
    if (stay_run) begin
      if (!cpu_at_term) begin
        cpu_cnt_d = cpu_cnt_q + 5'd1;
      end else if (cpu_hold) begin
        cpu_cnt_d = cpu_cnt_q;
      end
    end

    // Divisor only changes on RUN entry or at a wrap, never mid-period.
    div_sel_d = div_sel_q;
    if ((!run_q && run_d) || ce_cpu) begin
      div_sel_d = turbo;
    end

    lock_lost_d = lock_lost_q || (run_q && !lk_s_q);
  end

  // Sequencer and divider state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StWaitLock;
      lock_cnt_q  <= 16'd0;
      pix_cnt_q   <= 3'd0;
      cpu_cnt_q   <= 5'd0;
      div_sel_q   <= 2'd0;
      sys_rst_n_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      cpu_cnt_q   <= cpu_cnt_d;
      div_sel_q   <= div_sel_d;
      sys_rst_n_q <= run_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign sys_rst_n = sys_rst_n_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_kc_clk_enables.sv
// Directed bench for kc_clk_enables with LOCK_WAIT=16.
// Enables are checked in the cycle they are high: cycle "rel" is the one after edge R+rel,
// where R is the edge on which sys_rst_n rose.
module tb_kc_clk_enables;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic [1:0] turbo;
  logic       cpu_hold;
  logic       sys_rst_n;
  logic       ce_pix;
  logic       ce_cpu;
  logic       lock_lost;

  int n_cmp;
  int n_err;
  int rel;

  kc_clk_enables #(
    .LOCK_WAIT(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .turbo     (turbo),
    .cpu_hold  (cpu_hold),
    .sys_rst_n (sys_rst_n),
    .ce_pix    (ce_pix),
    .ce_cpu    (ce_cpu),
    .lock_lost (lock_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    turbo      = 2'd0;
    cpu_hold   = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({sys_rst_n, ce_pix, ce_cpu, lock_lost} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 0000", {sys_rst_n, ce_pix, ce_cpu, lock_lost});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    n_cmp++;
    if (sys_rst_n !== 1'b0) begin
      n_err++;
      $display("FAIL no_lock_hold: sys_rst_n got %b expected 0", sys_rst_n);
    end
  endtask

  task automatic test_lock_release();
    pll_locked = 1'b1;
    tick();  // E0
    for (int k = 1; k <= 18; k++) begin
      tick();
      n_cmp++;
      if (sys_rst_n !== (k == 18)) begin
        n_err++;
        $display("FAIL release_k%0d: sys_rst_n got %b expected %b", k, sys_rst_n, (k == 18));
      end
    end
    rel = 0;
    for (int j = 1; j <= 70; j++) begin
      tick();
      rel++;
      n_cmp++;
      if ({ce_pix, ce_cpu} !== {(rel % 8 == 7), (rel % 32 == 31)}) begin
        n_err++;
        $display("FAIL release_ce_rel%0d: pix/cpu got %b%b expected %b%b", rel, ce_pix, ce_cpu,
                 (rel % 8 == 7), (rel % 32 == 31));
      end
    end
  endtask

  task automatic test_lock_glitch();
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    pll_locked = 1'b1;
    tick();  // E0
    for (int k = 1; k <= 12; k++) tick();  // stabilisation count is 10 here
    pll_locked = 1'b0;
    tick();  // glitch sampled low
    pll_locked = 1'b1;
    tick();  // E1: re-lock sampled
    for (int k = 1; k <= 18; k++) begin
      tick();
      n_cmp++;
      if (sys_rst_n !== (k == 18)) begin
        n_err++;
        $display("FAIL glitch_k%0d: sys_rst_n got %b expected %b", k, sys_rst_n, (k == 18));
      end
    end
    n_cmp++;
    if (lock_lost !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_lock_lost: got %b expected 0", lock_lost);
    end
    rel = 0;
  endtask

  task automatic test_lock_loss();
    for (int k = 0; k < 4; k++) begin
      tick();
      rel++;
    end
    pll_locked = 1'b0;
    tick();  // L0
    tick();  // L0+1
    n_cmp++;
    if ({sys_rst_n, lock_lost} !== 2'b10) begin
      n_err++;
      $display("FAIL loss_l1: rst/lost got %b expected 10", {sys_rst_n, lock_lost});
    end
    tick();  // L0+2, would be a ce_pix cycle if still running
    n_cmp++;
    if ({sys_rst_n, lock_lost, ce_pix, ce_cpu} !== 4'b0100) begin
      n_err++;
      $display("FAIL loss_l2: rst/lost/pix/cpu got %b expected 0100",
               {sys_rst_n, lock_lost, ce_pix, ce_cpu});
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_cmp++;
      if ({sys_rst_n, ce_pix, ce_cpu} !== 3'b000) begin
        n_err++;
        $display("FAIL loss_quiet_k%0d: rst/pix/cpu got %b expected 000", k,
                 {sys_rst_n, ce_pix, ce_cpu});
      end
    end
    pll_locked = 1'b1;
    tick();  // E0
    for (int k = 1; k <= 18; k++) begin
      tick();
      n_cmp++;
      if (sys_rst_n !== (k == 18)) begin
        n_err++;
        $display("FAIL relock_k%0d: sys_rst_n got %b expected %b", k, sys_rst_n, (k == 18));
      end
    end
    n_cmp++;
    if (lock_lost !== 1'b1) begin
      n_err++;
      $display("FAIL relock_sticky: lock_lost got %b expected 1", lock_lost);
    end
    rel = 0;
  endtask

  task automatic test_turbo();
    logic exp_cpu;
    for (int j = 1; j <= 100; j++) begin
      tick();
      rel++;
      if (rel == 10) turbo = 2'd3;
      if (rel == 45) turbo = 2'd1;
      if (rel == 70) turbo = 2'd0;
      #1;
      exp_cpu = (rel == 31) || (rel == 35) || (rel == 39) || (rel == 43) || (rel == 47) ||
                (rel == 63) || (rel == 79);
      n_cmp++;
      if ({ce_pix, ce_cpu} !== {(rel % 8 == 7), exp_cpu}) begin
        n_err++;
        $display("FAIL turbo_rel%0d: pix/cpu got %b%b expected %b%b", rel, ce_pix, ce_cpu,
                 (rel % 8 == 7), exp_cpu);
      end
    end
  endtask

  task automatic test_cpu_hold();
    logic exp_cpu;
    for (int j = 101; j <= 215; j++) begin
      tick();
      rel++;
      cpu_hold = ((rel >= 143) && (rel <= 147)) || ((rel >= 185) && (rel <= 189));
      #1;
      exp_cpu = (rel == 111) || (rel == 148) || (rel == 180) || (rel == 212);
      n_cmp++;
      if ({ce_pix, ce_cpu} !== {(rel % 8 == 7), exp_cpu}) begin
        n_err++;
        $display("FAIL hold_rel%0d: pix/cpu got %b%b expected %b%b", rel, ce_pix, ce_cpu,
                 (rel % 8 == 7), exp_cpu);
      end
    end
    cpu_hold = 1'b0;
  endtask

  task automatic test_async_reset();
    // rel is 215 here: a ce_pix cycle, and lock_lost is still set.
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sys_rst_n, ce_pix, ce_cpu, lock_lost} !== 4'b0000) begin
      n_err++;
      $display("FAIL async_reset: rst/pix/cpu/lost got %b expected 0000",
               {sys_rst_n, ce_pix, ce_cpu, lock_lost});
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();  // E0: lock sampled high again
    for (int k = 1; k <= 18; k++) begin
      tick();
      n_cmp++;
      if (sys_rst_n !== (k == 18)) begin
        n_err++;
        $display("FAIL restart_k%0d: sys_rst_n got %b expected %b", k, sys_rst_n, (k == 18));
      end
    end
    for (int j = 1; j <= 8; j++) begin
      tick();
      n_cmp++;
      if (ce_pix !== (j == 7)) begin
        n_err++;
        $display("FAIL restart_pix_rel%0d: got %b expected %b", j, ce_pix, (j == 7));
      end
    end
    n_cmp++;
    if (lock_lost !== 1'b0) begin
      n_err++;
      $display("FAIL restart_lock_lost: got %b expected 0", lock_lost);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rel   = 0;
    test_reset();
    test_lock_release();
    test_lock_glitch();
    test_lock_loss();
    test_turbo();
    test_cpu_hold();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kc_clk_enables.md
# kc_clk_enables

Reset sequencer and clock-enable generator fed directly by the 56.75 MHz core PLL output and its `locked` flag. It holds the rest of the KC85/4 core in reset until the PLL has been stably locked for a programmable time. It then produces single-cycle clock enables: the 7.09375 MHz pixel rate (÷8) and the 1.7734 MHz Z80 rate (÷32, with turbo divisors ÷16/÷8/÷4). The whole core runs on the one PLL clock, gated by these enables.

## Interface
Parameters:
- `LOCK_WAIT`, default 4096: clk cycles `pll_locked` must stay high before release; legal range 2..65535.

Ports:
- `clk`  in  1: 56.75 MHz core clock, PLL `outclk_0`.
- `rst_n`  in  1: reset, asynchronous, active-low; one clock domain (`clk`) only.
- `pll_locked`  in  1: PLL lock flag, asynchronous to `clk`.
- `turbo`  in  2: CPU divisor select; 0=÷32, 1=÷16, 2=÷8, 3=÷4.
- `cpu_hold`  in  1: defers the next `ce_cpu` pulse (memory arbitration).
- `sys_rst_n`  out  1: registered, active-low reset for the rest of the core.
- `ce_pix`  out  1: one-cycle pixel enable, every 8th clk.
- `ce_cpu`  out  1: one-cycle Z80 enable.
- `lock_lost`  out  1: sticky flag, PLL lock dropped while in RUN.

## Operation
- `pll_locked` passes through a 2-flop synchronizer (`lk_s`), reset to 0.
- States:
  - WAIT_LOCK (reset state): go to STAB when `lk_s`=1. The 16-bit counter is cleared.
  - STAB: the counter increments each cycle. If `lk_s`=0, go to WAIT_LOCK. When counter = LOCK_WAIT-1, go to RUN.
  - RUN: if `lk_s`=0, go to WAIT_LOCK and set `lock_lost`.
- `sys_rst_n` = registered (next state == RUN), so it is 1 exactly while the state is RUN.
- Pixel divider: 3-bit counter, 0 outside RUN, increments in RUN. `ce_pix`=1 in the cycle the counter is 7, then it wraps to 0.
- CPU divider: 5-bit counter plus a latched divisor `div_l`.
  - `div_l` loads from `turbo` when entering RUN and at every wrap. `turbo` changes mid-period have no effect until the next wrap.
  - Counter 0 outside RUN; increments in RUN until it reaches `div_l`-1 (terminal).
  - At terminal with `cpu_hold`=0: `ce_cpu`=1 that cycle; the counter wraps to 0 and `div_l` reloads.
  - At terminal with `cpu_hold`=1: `ce_cpu`=0 and the counter holds at terminal. The pulse is deferred, never dropped.
  - `cpu_hold` is ignored when the counter is not at terminal.
- Outside RUN: `ce_pix`=`ce_cpu`=0 and both counters are 0.
- `lock_lost` clears only on `rst_n`.

## Timing
- Reset values (during `rst_n`=0, asynchronous):
  - state WAIT_LOCK; all counters 0; `lk_s` 0.
  - `sys_rst_n`=0, `ce_pix`=0, `ce_cpu`=0, `lock_lost`=0.
- Release latency: if `pll_locked` is first sampled high at edge E0 and stays high, `sys_rst_n` rises at edge E0+LOCK_WAIT+2.
  - The first `ce_pix` comes 8 clk after `sys_rst_n` rises.
  - The first `ce_cpu` comes `div_l` clk after `sys_rst_n` rises (32 for turbo=0).
- Lock loss: if `pll_locked` falls and is first sampled low at edge L0, then `sys_rst_n`=0 and `lock_lost`=1 from edge L0+2. Enables are 0 from the same edge.
- A glitch of `pll_locked` low in STAB (≥1 sampled cycle) restarts the full LOCK_WAIT count.
- `rst_n` asserted mid-RUN: all outputs go to reset values immediately (asynchronously). The full sequence restarts after deassertion.
- Steady state with no hold:
  - `ce_pix` period is exactly 8.
  - `ce_cpu` period is exactly `div_l`; pulses never sit in adjacent cycles.
  - Phase between `ce_pix` and `ce_cpu` is not guaranteed.
- A hold of H cycles that starts at terminal stretches that CPU period by H.

## Test plan
- Lock release, LOCK_WAIT=16, turbo=0: `pll_locked` 0→1 at E0 → `sys_rst_n`=1 at E0+18; `ce_pix` at +8,+16…; `ce_cpu` at +32,+64…
- Lock glitch in STAB: drop `pll_locked` for 1 cycle at count 10 → counter restarts; `sys_rst_n` rises 18 edges after re-lock is sampled; `lock_lost` stays 0.
- Lock loss in RUN: drop `pll_locked` → 2 edges later `sys_rst_n`=0, `lock_lost`=1, enables 0. Re-lock → release after LOCK_WAIT+2; `lock_lost` stays 1 until `rst_n`.
- Turbo change: switch turbo 0→3 mid-period → current period still 32; following periods 4. Switch 3→1 → next period 16.
- cpu_hold: assert for 5 cycles covering terminal at turbo=0 → `ce_cpu` deferred to the first cycle with hold low; that period 37, next 32. Hold not covering terminal → period 32.
- Async `rst_n` pulse mid-RUN → outputs reset without a clock edge; full sequence restarts after deassertion.
